// File: rtl/rx_command_parser.sv
// Turns UART receiver bytes into range-checked game commands (1-byte 'N', 3-byte 'R'/'F' row col).
// One command is held on cmd_valid until accepted; malformed, late or unconsumed bytes are reported.
module rx_command_parser #(
  parameter int ROWS    = 16,
  parameter int COLS    = 16,
  parameter int TIMEOUT = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxfinish,
  input  logic [7:0] rxdata,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_op,
  output logic [7:0] cmd_row,
  output logic [7:0] cmd_col,
  output logic       cmd_error,
  output logic [1:0] err_code,
  output logic       overrun,
  output logic       busy
);

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLOAD   = CW'(TIMEOUT - 1);
  localparam logic [7:0]    ROW_LIM = 8'(ROWS);
  localparam logic [7:0]    COL_LIM = 8'(COLS);

  localparam logic [7:0] OP_REVEAL = 8'h52;
  localparam logic [7:0] OP_FLAG   = 8'h46;
  localparam logic [7:0] OP_NEW    = 8'h4E;

  localparam logic [1:0] ERR_OPCODE  = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GOT_OP  = 2'd1,
    GOT_ROW = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t        state_q;
  logic          rxfinish_q;
  logic [CW-1:0] timer_q;
  logic [1:0]    op_q;
  logic [7:0]    row_q;
  logic [7:0]    col_q;
  logic          valid_q;
  logic          error_q;
  logic [1:0]    code_q;
  logic          overrun_q;
  logic          busy_q;

  logic strobe;
  logic timer_zero;

  // rxfinish_q resets high (receiver idles high), so leaving reset is never a strobe.
  assign strobe     = rxfinish & ~rxfinish_q;
  assign timer_zero = (timer_q == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rxfinish_q <= 1'b1;
      timer_q    <= '0;
      op_q       <= 2'b00;
      row_q      <= 8'd0;
      col_q      <= 8'd0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      code_q     <= 2'b00;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rxfinish_q <= rxfinish;
      error_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (strobe) begin
            case (rxdata)
              OP_NEW: begin
                state_q <= HOLD;
                op_q    <= 2'b10;
                row_q   <= 8'd0;
                col_q   <= 8'd0;
                valid_q <= 1'b1;
              end
              OP_REVEAL, OP_FLAG: begin
                state_q <= GOT_OP;
                op_q    <= (rxdata == OP_FLAG) ? 2'b01 : 2'b00;
                timer_q <= TLOAD;
                busy_q  <= 1'b1;
              end
              default: begin
                error_q <= 1'b1;
                code_q  <= ERR_OPCODE;
              end
            endcase
          end
        end
        GOT_OP: begin
          // A strobe on the last counter cycle still wins over the timeout.
          if (strobe) begin
            row_q   <= rxdata;
            state_q <= GOT_ROW;
            timer_q <= TLOAD;
          end else if (timer_zero) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
            code_q  <= ERR_TIMEOUT;
          end else begin
            timer_q <= timer_q - CW'(1);
          end
        end
        GOT_ROW: begin
          if (strobe) begin
            col_q  <= rxdata;
            busy_q <= 1'b0;
            if ((row_q < ROW_LIM) && (rxdata < COL_LIM)) begin
              state_q <= HOLD;
              valid_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              error_q <= 1'b1;
              code_q  <= ERR_RANGE;
            end
          end else if (timer_zero) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
            code_q  <= ERR_TIMEOUT;
          end else begin
            timer_q <= timer_q - CW'(1);
          end
        end
        HOLD: begin
          if (cmd_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
          // Bytes arriving while a command waits are dropped, even on the handshake cycle.
          if (strobe) begin
            overrun_q <= 1'b1;
          end else if (cmd_ready) begin
            overrun_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_op    = op_q;
  assign cmd_row   = row_q;
  assign cmd_col   = col_q;
  assign cmd_error = error_q;
  assign err_code  = code_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rx_command_parser.sv
// Directed bench for rx_command_parser: vector table for single frames plus hand sequences for timing corners.
module tb_rx_command_parser;

  logic       clock = 1'b0;
  logic       reset;
  logic       rxfinish;
  logic [7:0] rxdata;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [7:0] cmd_row;
  logic [7:0] cmd_col;
  logic       cmd_error;
  logic [1:0] err_code;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;

  rx_command_parser #(.ROWS(16), .COLS(12), .TIMEOUT(20)) dut (
    .clock     (clock),
    .reset     (reset),
    .rxfinish  (rxfinish),
    .rxdata    (rxdata),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_row   (cmd_row),
    .cmd_col   (cmd_col),
    .cmd_error (cmd_error),
    .err_code  (err_code),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    logic       valid;
    logic [1:0] op;
    logic [7:0] row;
    logic [7:0] col;
    logic       err;
    logic [1:0] code;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One receiver byte: rxfinish low for a cycle, then rises; returns just after the parser registers it.
  task automatic send(input logic [7:0] b);
    @(posedge clock);
    #1;
    rxfinish = 1'b0;
    rxdata   = b;
    @(posedge clock);
    #1;
    rxfinish = 1'b1;
    step();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " valid"},   cmd_valid, 0);
    chk({tag, " op"},      cmd_op,    0);
    chk({tag, " row"},     cmd_row,   0);
    chk({tag, " col"},     cmd_col,   0);
    chk({tag, " error"},   cmd_error, 0);
    chk({tag, " code"},    err_code,  0);
    chk({tag, " overrun"}, overrun,   0);
    chk({tag, " busy"},    busy,      0);
  endtask

  vec_t tbl [10];
  int   cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h52, 8'h03, 8'h07, 3, 1'b1, 2'd0, 8'd3,  8'd7,  1'b0, 2'd0};
    tbl[1] = '{8'h46, 8'h0F, 8'h0B, 3, 1'b1, 2'd1, 8'd15, 8'd11, 1'b0, 2'd0};
    tbl[2] = '{8'h52, 8'h10, 8'h00, 3, 1'b0, 2'd0, 8'd0,  8'd0,  1'b1, 2'd2};
    tbl[3] = '{8'h52, 8'h00, 8'h0C, 3, 1'b0, 2'd0, 8'd0,  8'd0,  1'b1, 2'd2};
    tbl[4] = '{8'h4E, 8'h00, 8'h00, 1, 1'b1, 2'd2, 8'd0,  8'd0,  1'b0, 2'd0};
    tbl[5] = '{8'h58, 8'h00, 8'h00, 1, 1'b0, 2'd0, 8'd0,  8'd0,  1'b1, 2'd1};
    tbl[6] = '{8'h46, 8'h00, 8'h00, 3, 1'b1, 2'd1, 8'd0,  8'd0,  1'b0, 2'd0};
    tbl[7] = '{8'h72, 8'h00, 8'h00, 1, 1'b0, 2'd0, 8'd0,  8'd0,  1'b1, 2'd1};
    tbl[8] = '{8'h46, 8'hFF, 8'hFF, 3, 1'b0, 2'd0, 8'd0,  8'd0,  1'b1, 2'd2};
    tbl[9] = '{8'h00, 8'h00, 8'h00, 1, 1'b0, 2'd0, 8'd0,  8'd0,  1'b1, 2'd1};

    reset     = 1'b1;
    rxfinish  = 1'b1;
    rxdata    = 8'h00;
    cmd_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk_reset_values("reset");
    step();
    chk("reset no strobe valid", cmd_valid, 0);

    // Reveal 3,7 with busy tracked between bytes.
    cmd_ready = 1'b1;
    send(8'h52);
    chk("r37 busy after op", busy, 1);
    send(8'h03);
    chk("r37 busy after row", busy, 1);
    send(8'h07);
    chk("r37 valid", cmd_valid, 1);
    chk("r37 op", cmd_op, 0);
    chk("r37 row", cmd_row, 3);
    chk("r37 col", cmd_col, 7);
    chk("r37 busy", busy, 0);
    chk("r37 error", cmd_error, 0);
    step();
    chk("r37 valid drops", cmd_valid, 0);

    // New game held for 20 cycles without ready, then accepted.
    cmd_ready = 1'b0;
    send(8'h4E);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_valid && cmd_op == 2'b10 && cmd_row == 8'd0 && cmd_col == 8'd0) cnt++;
      step();
    end
    cmd_ready = 1'b1;
    if (cmd_valid) cnt++;
    step();
    cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (cmd_valid) cnt++;
      step();
    end
    chk("new hold cycles", cnt, 21);

    cmd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].b0);
      if (tbl[i].n > 1) begin
        send(tbl[i].b1);
        send(tbl[i].b2);
      end
      chk($sformatf("vec%0d valid", i), cmd_valid, tbl[i].valid);
      chk($sformatf("vec%0d error", i), cmd_error, tbl[i].err);
      chk($sformatf("vec%0d busy", i), busy, 0);
      if (tbl[i].valid) begin
        chk($sformatf("vec%0d op", i), cmd_op, tbl[i].op);
        chk($sformatf("vec%0d row", i), cmd_row, tbl[i].row);
        chk($sformatf("vec%0d col", i), cmd_col, tbl[i].col);
      end
      if (tbl[i].err) chk($sformatf("vec%0d code", i), err_code, tbl[i].code);
      step();
      chk($sformatf("vec%0d valid after", i), cmd_valid, 0);
      chk($sformatf("vec%0d error after", i), cmd_error, 0);
    end

    // Timeout: no byte for 20 clocks after the row byte.
    send(8'h52);
    send(8'h01);
    repeat (19) step();
    chk("tmo not yet error", cmd_error, 0);
    chk("tmo not yet busy", busy, 1);
    step();
    chk("tmo error", cmd_error, 1);
    chk("tmo code", err_code, 3);
    chk("tmo busy", busy, 0);
    chk("tmo valid", cmd_valid, 0);
    step();
    chk("tmo error pulse", cmd_error, 0);

    // Column byte strobed on the very cycle the counter reaches zero is accepted.
    send(8'h52);
    send(8'h01);
    repeat (17) @(posedge clock);
    send(8'h01);
    chk("edge valid", cmd_valid, 1);
    chk("edge error", cmd_error, 0);
    chk("edge row", cmd_row, 1);
    chk("edge col", cmd_col, 1);
    step();

    // Overrun while a command waits; command stays intact.
    cmd_ready = 1'b0;
    send(8'h52);
    send(8'h02);
    send(8'h02);
    chk("ovr valid", cmd_valid, 1);
    chk("ovr pre overrun", overrun, 0);
    send(8'h4E);
    chk("ovr overrun", overrun, 1);
    chk("ovr still valid", cmd_valid, 1);
    chk("ovr op", cmd_op, 0);
    chk("ovr row", cmd_row, 2);
    chk("ovr col", cmd_col, 2);
    cmd_ready = 1'b1;
    step();
    chk("ovr handshake valid", cmd_valid, 0);
    chk("ovr cleared", overrun, 0);

    // Strobe and ready together: handshake completes, byte dropped, overrun set.
    cmd_ready = 1'b0;
    send(8'h52);
    send(8'h04);
    send(8'h04);
    chk("same valid", cmd_valid, 1);
    @(posedge clock);
    #1;
    rxfinish = 1'b0;
    rxdata   = 8'h4E;
    @(posedge clock);
    #1;
    rxfinish  = 1'b1;
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    chk("same valid drop", cmd_valid, 0);
    chk("same overrun", overrun, 1);
    chk("same row held", cmd_row, 4);
    step();
    chk("same byte dropped", cmd_valid, 0);
    send(8'h4E);
    chk("same next valid", cmd_valid, 1);
    chk("same next op", cmd_op, 2);
    chk("same overrun held", overrun, 1);
    cmd_ready = 1'b1;
    step();
    chk("same overrun clear", overrun, 0);

    // Reset in the middle of a frame.
    send(8'h52);
    send(8'h05);
    chk("rst busy before", busy, 1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_values("midreset");
    send(8'h46);
    send(8'h00);
    send(8'h00);
    chk("post rst valid", cmd_valid, 1);
    chk("post rst op", cmd_op, 1);
    chk("post rst row", cmd_row, 0);
    chk("post rst col", cmd_col, 0);
    chk("post rst error", cmd_error, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
